vec_add_stream: RTL and testbench

- Streaming element-wise vector adder.
- A one-cycle start pulse launches a pass over LENGTH elements. For each index it reads operand A from memory port v0 and operand B from v1, then writes the widened sum to result memory port v2 at the same index.
- Attaches to three external synchronous single-port memories: two read-only, one write-only.
- Throughput is one element per clock.

---
 rtl/vec_add_stream.sv | 144 ++++++++++++++
 tb/tb_vec_add_stream.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vec_add_stream.sv
// vec_add_stream: streaming element-wise vector adder.
// On a start pulse it reads LENGTH operand pairs from two synchronous read
// memories (v0, v1) at one element per clock and writes the widened sums to
// a third memory (v2) at the same index, two cycles after each read.
// Optional build macro: VEC_ADD_STREAM_SIGNED_EN selects two's-complement
// operands with sign extension; otherwise operands are unsigned.
module vec_add_stream #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OUT_W  = 64,
  parameter int unsigned LENGTH = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tstart,
  output logic [ADDR_W-1:0] v0_addr,
  output logic              v0_rd_en,
  input  logic [DATA_W-1:0] v0_rd_data,
  output logic [ADDR_W-1:0] v1_addr,
  output logic              v1_rd_en,
  input  logic [DATA_W-1:0] v1_rd_data,
  output logic [ADDR_W-1:0] v2_addr,
  output logic              v2_wr_en,
  output logic [OUT_W-1:0]  v2_wr_data
);

  // Counter is one bit wider than the address so it can reach LENGTH.
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  idx;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              p1_valid;
  logic [ADDR_W-1:0] p1_addr;
  logic [OUT_W-1:0]  sum_c;

  // Both operand memories are read in lockstep from the same registers.
  assign v0_rd_en = rd_en_q;
  assign v1_rd_en = rd_en_q;
  assign v0_addr  = rd_addr_q;
  assign v1_addr  = rd_addr_q;

`ifdef VEC_ADD_STREAM_SIGNED_EN
  logic signed [DATA_W:0] sum_s_c;

  // Signed add at DATA_W+1 bits, then sign-extend to the result width.
  always_comb begin
    sum_s_c = $signed({v0_rd_data[DATA_W-1], v0_rd_data})
            + $signed({v1_rd_data[DATA_W-1], v1_rd_data});
    sum_c   = OUT_W'(sum_s_c);
  end
`else
  logic [DATA_W:0] sum_u_c;

  // Unsigned add at DATA_W+1 bits, then zero-extend to the result width.
  always_comb begin
    sum_u_c = {1'b0, v0_rd_data} + {1'b0, v1_rd_data};
    sum_c   = OUT_W'(sum_u_c);
  end
`endif

  // Control FSM: issues one read per cycle for indices 0..LENGTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          rd_en_q   <= 1'b0;
          rd_addr_q <= '0;
          if (tstart) begin
            state     <= RUN;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            idx       <= CNT_W'(1);
          end
        end
        RUN: begin
          if (idx == CNT_W'(LENGTH)) begin
            state     <= DRAIN;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            idx       <= '0;
          end else begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= ADDR_W'(idx);
            idx       <= idx + CNT_W'(1);
          end
        end
        DRAIN: begin
          rd_en_q   <= 1'b0;
          rd_addr_q <= '0;
          // Last write is registered once the pipeline has emptied.
          if (!p1_valid) begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          idx       <= '0;
          rd_en_q   <= 1'b0;
          rd_addr_q <= '0;
        end
      endcase
    end
  end

  // Tracks which index has read data arriving this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid <= 1'b0;
      p1_addr  <= '0;
    end else begin
      p1_valid <= rd_en_q;
      p1_addr  <= rd_addr_q;
    end
  end

  // Registers the sum and issues the write; data holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_wr_en   <= 1'b0;
      v2_addr    <= '0;
      v2_wr_data <= '0;
    end else begin
      v2_wr_en <= p1_valid;
      v2_addr  <= p1_valid ? p1_addr : '0;
      if (p1_valid) begin
        v2_wr_data <= sum_c;
      end
    end
  end

endmodule

// File: tb/tb_vec_add_stream.sv
// Bench for vec_add_stream: memory models, reference sums, directed passes.
module tb_vec_add_stream;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OUT_W  = 64;
  localparam int unsigned LENGTH = 128;
  localparam int PASS_CYC = LENGTH + 10;

  logic              clk;
  logic              rst_n;
  logic              tstart;
  logic [ADDR_W-1:0] v0_addr;
  logic              v0_rd_en;
  logic [DATA_W-1:0] v0_rd_data;
  logic [ADDR_W-1:0] v1_addr;
  logic              v1_rd_en;
  logic [DATA_W-1:0] v1_rd_data;
  logic [ADDR_W-1:0] v2_addr;
  logic              v2_wr_en;
  logic [OUT_W-1:0]  v2_wr_data;

  logic [DATA_W-1:0] mem0 [LENGTH];
  logic [DATA_W-1:0] mem1 [LENGTH];
  logic [OUT_W-1:0]  mem2 [LENGTH];

  int checks;
  int failures;
  int wr_cnt;
  logic [OUT_W-1:0] last_wr;

  vec_add_stream #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_W(OUT_W), .LENGTH(LENGTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tstart(tstart),
    .v0_addr(v0_addr), .v0_rd_en(v0_rd_en), .v0_rd_data(v0_rd_data),
    .v1_addr(v1_addr), .v1_rd_en(v1_rd_en), .v1_rd_data(v1_rd_data),
    .v2_addr(v2_addr), .v2_wr_en(v2_wr_en), .v2_wr_data(v2_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories: one-cycle read latency, write on enable.
  always @(posedge clk) begin
    if (v0_rd_en) v0_rd_data <= mem0[v0_addr];
    if (v1_rd_en) v1_rd_data <= mem1[v1_addr];
    if (v2_wr_en) mem2[v2_addr] <= v2_wr_data;
  end

  // Reference sum straight from the arithmetic definition.
  function automatic logic [OUT_W-1:0] ref_sum(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef VEC_ADD_STREAM_SIGNED_EN
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return OUT_W'(sa + sb);
`else
    return OUT_W'(a) + OUT_W'(b);
`endif
  endfunction

  task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All enables and addresses low; write data holds its last value.
  task automatic check_idle(input string tag);
    chk({tag, "_v0_en"}, OUT_W'(v0_rd_en), '0);
    chk({tag, "_v1_en"}, OUT_W'(v1_rd_en), '0);
    chk({tag, "_v0_addr"}, OUT_W'(v0_addr), '0);
    chk({tag, "_v1_addr"}, OUT_W'(v1_addr), '0);
    chk({tag, "_v2_en"}, OUT_W'(v2_wr_en), '0);
    chk({tag, "_v2_addr"}, OUT_W'(v2_addr), '0);
    chk({tag, "_v2_data"}, v2_wr_data, last_wr);
  endtask

  // Expected outputs t cycles after the start edge.
  task automatic check_cycle(input int t);
    logic exp_rd;
    logic exp_wr;
    int   ri;
    int   wi;
    exp_rd = (t >= 1) && (t <= LENGTH);
    exp_wr = (t >= 3) && (t <= LENGTH + 2);
    ri = exp_rd ? t - 1 : 0;
    wi = exp_wr ? t - 3 : 0;
    if (exp_wr) last_wr = ref_sum(mem0[wi], mem1[wi]);
    if (v2_wr_en) wr_cnt++;
    chk("v0_rd_en", OUT_W'(v0_rd_en), OUT_W'(exp_rd));
    chk("v1_rd_en", OUT_W'(v1_rd_en), OUT_W'(exp_rd));
    chk("v0_addr", OUT_W'(v0_addr), OUT_W'(ri));
    chk("v1_addr", OUT_W'(v1_addr), OUT_W'(ri));
    chk("v2_wr_en", OUT_W'(v2_wr_en), OUT_W'(exp_wr));
    chk("v2_addr", OUT_W'(v2_addr), OUT_W'(wi));
    chk("v2_wr_data", v2_wr_data, last_wr);
  endtask

  // One pass: start pulse, optional ignored re-pulse, optional mid-pass reset.
  task automatic run_pass(input int repulse_at, input int abort_at);
    wr_cnt = 0;
    @(negedge clk);
    tstart = 1'b1;
    @(posedge clk);
    for (int t = 1; t <= PASS_CYC; t++) begin
      @(negedge clk);
      tstart = (t == repulse_at);
      check_cycle(t);
      if (t == abort_at) begin
        #1 rst_n = 1'b0;
        #1 last_wr = '0;
        check_idle("async_rst");
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          check_idle("in_rst");
        end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          check_idle("post_rst");
        end
        tstart = 1'b0;
        return;
      end
    end
    tstart = 1'b0;
  endtask

  task automatic fill_random();
    for (int a = 0; a < LENGTH; a++) begin
      mem0[a] = $urandom;
      mem1[a] = $urandom;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    wr_cnt   = 0;
    last_wr  = '0;
    tstart   = 1'b0;
    rst_n    = 1'b0;
    v0_rd_data = '0;
    v1_rd_data = '0;
    for (int a = 0; a < LENGTH; a++) begin
      mem0[a] = '0;
      mem1[a] = '0;
      mem2[a] = '0;
    end

    // Reset state and idle quiescence.
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      check_idle("idle");
    end

    // Basic pass with the documented ramp pattern.
    for (int a = 0; a < LENGTH; a++) begin
      mem0[a] = DATA_W'(a + 5);
      mem1[a] = DATA_W'(a + 100);
    end
    run_pass(0, 0);
    chk("basic_wr_cnt", OUT_W'(wr_cnt), OUT_W'(LENGTH));
    chk("basic_v2_0", mem2[0], 64'd105);
    chk("basic_v2_127", mem2[127], 64'd359);

    // Random operands.
    for (int p = 0; p < 2; p++) begin
      fill_random();
      run_pass(0, 0);
      chk("rand_wr_cnt", OUT_W'(wr_cnt), OUT_W'(LENGTH));
      for (int a = 0; a < LENGTH; a++) chk("rand_mem2", mem2[a], ref_sum(mem0[a], mem1[a]));
    end

    // Carry into the extra bit.
    for (int a = 0; a < LENGTH; a++) begin
      mem0[a] = 32'hFFFF_FFFF;
      mem1[a] = 32'hFFFF_FFFF;
    end
    run_pass(0, 0);
`ifdef VEC_ADD_STREAM_SIGNED_EN
    chk("carry_v2_0", mem2[0], 64'hFFFF_FFFF_FFFF_FFFE);
    chk("carry_v2_127", mem2[127], 64'hFFFF_FFFF_FFFF_FFFE);
`else
    chk("carry_v2_0", mem2[0], 64'h0000_0001_FFFF_FFFE);
    chk("carry_v2_127", mem2[127], 64'h0000_0001_FFFF_FFFE);
`endif

    // Start while busy is ignored; a later start gives a full second pass.
    fill_random();
    run_pass(50, 0);
    chk("busy_wr_cnt", OUT_W'(wr_cnt), OUT_W'(LENGTH));
    fill_random();
    run_pass(0, 0);
    chk("second_wr_cnt", OUT_W'(wr_cnt), OUT_W'(LENGTH));

    // Reset mid-pass, then restart from address 0.
    fill_random();
    run_pass(0, 40);
    fill_random();
    run_pass(0, 0);
    chk("restart_wr_cnt", OUT_W'(wr_cnt), OUT_W'(LENGTH));
    chk("restart_v2_0", mem2[0], ref_sum(mem0[0], mem1[0]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
